// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// 64-bit free-running timer counter with a 64-bit compare register and a
// sticky, maskable match interrupt. Increments on cnt_en pulses from cnt_ctrl
// and exposes its registers over a word-addressed read/write port.
//
// Register map (reg_addr):
//   0 CNT_LO   1 CNT_HI   2 CMP_LO   3 CMP_HI
//   4 INT_EN (bit 0)      5 INT_STS (bit 0, write-1-to-clear)
//   6-7 reserved (read 0, writes ignored)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   cnt_en     increment strobe (already gated by halt/prescaler)
//   timer_en   timer enable; a 1->0 transition clears the counter
//   reg_wr     single-cycle write strobe
//   reg_rd     single-cycle read strobe
//   reg_addr   word index
//   reg_wdata  write data
//   reg_rdata  registered read data (valid the cycle after reg_rd)
//   tim_int    registered interrupt, int_st & int_en
//
// Parameters:
//   CMP_RST    reset value of the compare register
//
// Optional feature macro: TIMER_CNT_SNAPSHOT_EN
//   When defined, a CNT_LO read latches cnt[63:32] into a shadow register and
//   CNT_HI reads return that shadow, so a LO-then-HI read pair is coherent.
//   When undefined, CNT_HI reads return the live upper counter half.
// ---------------------------------------------------------------------------
module timer_counter #(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_en,
  input  logic        timer_en,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        tim_int
);

  localparam logic [2:0] ADDR_CNT_LO  = 3'd0;
  localparam logic [2:0] ADDR_CNT_HI  = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO  = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI  = 3'd3;
  localparam logic [2:0] ADDR_INT_EN  = 3'd4;
  localparam logic [2:0] ADDR_INT_STS = 3'd5;

  logic [63:0] cnt;
  logic [63:0] cmp;
  logic        int_en;
  logic        int_st;
  logic        timer_en_d;

  logic        wr_cnt_lo;
  logic        wr_cnt_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_int_en;
  logic        clr_int_st;
  logic        rd_cnt_lo;
  logic        cnt_clear;
  logic        match;
  logic [31:0] cnt_hi_rd;
  logic [31:0] rd_mux;

  // Write/read decode.
  assign wr_cnt_lo  = reg_wr && (reg_addr == ADDR_CNT_LO);
  assign wr_cnt_hi  = reg_wr && (reg_addr == ADDR_CNT_HI);
  assign wr_cmp_lo  = reg_wr && (reg_addr == ADDR_CMP_LO);
  assign wr_cmp_hi  = reg_wr && (reg_addr == ADDR_CMP_HI);
  assign wr_int_en  = reg_wr && (reg_addr == ADDR_INT_EN);
  assign clr_int_st = reg_wr && (reg_addr == ADDR_INT_STS) && reg_wdata[0];
  assign rd_cnt_lo  = reg_rd && (reg_addr == ADDR_CNT_LO);

  // Falling edge of timer_en, seen against last cycle's registered value.
  assign cnt_clear = timer_en_d && !timer_en;

  // Match on registered state only, so it is level-based and re-asserts every
  // cycle the counter rests on the compare value.
  assign match = (cnt == cmp);

`ifdef TIMER_CNT_SNAPSHOT_EN
  logic [31:0] cnt_hi_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_hi_shadow <= 32'h0;
    end else if (rd_cnt_lo) begin
      cnt_hi_shadow <= cnt[63:32];
    end
  end

  assign cnt_hi_rd = cnt_hi_shadow;
`else
  // Without the shadow, CNT_LO reads have no side effect.
  logic unused_rd_cnt_lo;
  assign unused_rd_cnt_lo = rd_cnt_lo;
  assign cnt_hi_rd        = cnt[63:32];
`endif

  // Read mux sees pre-write state, so a simultaneous write+read returns the
  // old value.
  always_comb begin
    // NOTE: default assignment first so no path leaves rd_mux unassigned,
    // which would otherwise infer a latch.
    rd_mux = 32'h0;
    unique case (reg_addr)
      ADDR_CNT_LO:  rd_mux = cnt[31:0];
      ADDR_CNT_HI:  rd_mux = cnt_hi_rd;
      ADDR_CMP_LO:  rd_mux = cmp[31:0];
      ADDR_CMP_HI:  rd_mux = cmp[63:32];
      ADDR_INT_EN:  rd_mux = {31'b0, int_en};
      ADDR_INT_STS: rd_mux = {31'b0, int_st};
      default:      rd_mux = 32'h0;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours (e.g. tim_int uses
  // the old int_st, reg_rdata uses the old cnt).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 64'h0;
      cmp        <= CMP_RST;
      int_en     <= 1'b0;
      int_st     <= 1'b0;
      timer_en_d <= 1'b0;
      reg_rdata  <= 32'h0;
      tim_int    <= 1'b0;
    end else begin
      timer_en_d <= timer_en;

      // Counter: disable-clear beats register write beats increment.
      if (cnt_clear) begin
        cnt <= 64'h0;
      end else if (wr_cnt_lo) begin
        cnt[31:0] <= reg_wdata;
      end else if (wr_cnt_hi) begin
        cnt[63:32] <= reg_wdata;
      end else if (cnt_en) begin
        cnt <= cnt + 64'd1;
      end

      if (wr_cmp_lo) cmp[31:0]  <= reg_wdata;
      if (wr_cmp_hi) cmp[63:32] <= reg_wdata;
      if (wr_int_en) int_en     <= reg_wdata[0];

      // Set has priority over write-1-to-clear.
      if (match) begin
        int_st <= 1'b1;
      end else if (clr_int_st) begin
        int_st <= 1'b0;
      end

      tim_int <= int_st & int_en;

      if (reg_rd) reg_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_en;
  logic        timer_en;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        tim_int;

  int n_vec  = 0;
  int n_fail = 0;

  timer_counter dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_en    (cnt_en),
    .timer_en  (timer_en),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .tim_int   (tim_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        cnt_en;
    logic        timer_en;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_int;
  } vec_t;

  vec_t vecs[$];

`ifdef TIMER_CNT_SNAPSHOT_EN
  localparam logic [31:0] SNAP_HI = 32'd1;
`else
  localparam logic [31:0] SNAP_HI = 32'd2;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic ce, input logic te, input logic wr,
                     input logic rd, input logic [2:0] a, input logic [31:0] wd,
                     input logic chk, input logic [31:0] er, input logic ei);
    vec_t v;
    v.name = n; v.cnt_en = ce; v.timer_en = te; v.wr = wr; v.rd = rd;
    v.addr = a; v.wdata = wd; v.chk_rd = chk; v.exp_rdata = er; v.exp_int = ei;
    vecs.push_back(v);
  endtask

  // Shorthands: read with timer enabled, write with timer enabled.
  task automatic add_rd(input string n, input logic [2:0] a, input logic [31:0] er, input logic ei);
    add(n, 1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0, 1'b1, er, ei);
  endtask

  task automatic add_wr(input string n, input logic ce, input logic [2:0] a,
                        input logic [31:0] wd, input logic ei);
    add(n, ce, 1'b1, 1'b1, 1'b0, a, wd, 1'b0, 32'h0, ei);
  endtask

  task automatic drive(input logic ce, input logic te, input logic wr, input logic rd,
                       input logic [2:0] a, input logic [31:0] wd);
    cnt_en = ce; timer_en = te; reg_wr = wr; reg_rd = rd; reg_addr = a; reg_wdata = wd;
  endtask

  // Apply for one cycle and sample 1 time unit after the edge.
  task automatic cycle(input logic ce, input logic te, input logic wr, input logic rd,
                       input logic [2:0] a, input logic [31:0] wd);
    drive(ce, te, wr, rd, a, wd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);

    // ---------------- vector table ----------------
    add_rd("rd_rsvd6",      3'd6, 32'h0,        1'b0);
    add_rd("rst_cnt_lo",    3'd0, 32'h0,        1'b0);
    add_rd("rst_cmp_lo",    3'd2, 32'hFFFFFFFF, 1'b0);
    add_rd("rst_cmp_hi",    3'd3, 32'hFFFFFFFF, 1'b0);
    add_rd("rst_int_en",    3'd4, 32'h0,        1'b0);
    add_rd("rst_int_sts",   3'd5, 32'h0,        1'b0);
    // carry from low into high half
    add_wr("wr_lo_ones",    1'b0, 3'd0, 32'hFFFFFFFF, 1'b0);
    add_wr("wr_hi_zero",    1'b0, 3'd1, 32'h0,        1'b0);
    add   ("inc_carry",     1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add_rd("carry_hi",      3'd1, 32'd1,        1'b0);
    add_rd("carry_lo",      3'd0, 32'd0,        1'b0);
    // 64-bit wrap from all-ones (also matches reset cmp; int_en still 0)
    add_wr("wr_lo_ones2",   1'b0, 3'd0, 32'hFFFFFFFF, 1'b0);
    add_wr("wr_hi_ones",    1'b0, 3'd1, 32'hFFFFFFFF, 1'b0);
    add   ("inc_wrap",      1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add_rd("wrap_lo",       3'd0, 32'd0,        1'b0);
    add_rd("wrap_hi",       3'd1, 32'd0,        1'b0);
    add_rd("sts_masked",    3'd5, 32'd1,        1'b0);
    add_wr("w1c_sts",       1'b0, 3'd5, 32'd1,  1'b0);
    add_rd("sts_cleared",   3'd5, 32'd0,        1'b0);
    // simultaneous write+read returns the pre-write value
    add   ("wr_rd_cmp_lo",  1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 32'd5, 1'b1, 32'hFFFFFFFF, 1'b0);
    add_wr("wr_cmp_hi",     1'b0, 3'd3, 32'd0,  1'b0);
    add_rd("cmp_lo_vis",    3'd2, 32'd5,        1'b0);
    add_wr("wr_rsvd7",      1'b0, 3'd7, 32'hDEADBEEF, 1'b0);
    add_rd("rd_rsvd7",      3'd7, 32'h0,        1'b0);
    // compare interrupt, cnt_en held high from 0
    add_wr("int_en_on",     1'b0, 3'd4, 32'd1,  1'b0);
    add   ("inc_1",         1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add   ("inc_2",         1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add   ("inc_3",         1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add   ("inc_4",         1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add   ("inc_5",         1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add   ("inc_6_sts_set", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add   ("inc_7_int_up",  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    add_wr("w1c_at_7",      1'b1, 3'd5, 32'd1,  1'b1);
    add   ("int_drop",      1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    // W1C colliding with an active match: set wins
    add_wr("cmp_lo_10",     1'b0, 3'd2, 32'd10, 1'b0);
    add   ("inc_10",        1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add_wr("w1c_on_match",  1'b0, 3'd5, 32'd1,  1'b0);
    add_rd("sts_set_wins",  3'd5, 32'd1,        1'b1);
    add_wr("w1c_on_match2", 1'b0, 3'd5, 32'd1,  1'b1);
    add   ("inc_11",        1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    add_wr("w1c_no_match",  1'b0, 3'd5, 32'd1,  1'b1);
    add   ("idle_int_low",  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add_rd("sts_clear2",    3'd5, 32'd0,        1'b0);
    // CNT_LO write beats cnt_en
    add_wr("lo_wr_and_inc", 1'b1, 3'd0, 32'h12345678, 1'b0);
    add_rd("lo_no_inc",     3'd0, 32'h12345678, 1'b0);
    add_rd("hi_untouched",  3'd1, 32'h0,        1'b0);
    // disable clear (beats cnt_en), then stays 0 while disabled
    add_wr("cnt_100",       1'b0, 3'd0, 32'd100, 1'b0);
    add_rd("rd_100",        3'd0, 32'd100,      1'b0);
    add   ("timer_off",     1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add   ("off_rd_0",      1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h0, 1'b0);
    add   ("off_hold_0",    1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h0, 1'b0);
    // LO-then-HI read across an increment
    add_wr("snap_hi_1",     1'b0, 3'd1, 32'd1,  1'b0);
    add_wr("snap_lo_ones",  1'b0, 3'd0, 32'hFFFFFFFF, 1'b0);
    add_rd("snap_rd_lo",    3'd0, 32'hFFFFFFFF, 1'b0);
    add   ("snap_inc",      1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    add_rd("snap_rd_hi",    3'd1, SNAP_HI,      1'b0);
    add_rd("snap_rd_lo2",   3'd0, 32'h0,        1'b0);

    // ---------------- reset ----------------
    @(posedge clk); #1;
    check("rst_rdata",   reg_rdata,        32'h0);
    check("rst_tim_int", {31'b0, tim_int}, 32'h0);
    rst = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      cycle(vecs[i].cnt_en, vecs[i].timer_en, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rd) check({vecs[i].name, "_rdata"}, reg_rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_int"}, {31'b0, tim_int}, {31'b0, vecs[i].exp_int});
    end

    // ---------------- mid-operation async reset ----------------
    // cnt is 2_0000_0000; make cmp equal it so tim_int rises.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 32'd2);  // cmp matches after this edge
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 32'h0);  // int_st set; rdata <= 2
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);  // tim_int set
    check("pre_rst_rdata", reg_rdata,        32'd2);
    check("pre_rst_int",   {31'b0, tim_int}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata", reg_rdata,        32'h0);
    check("async_rst_int",   {31'b0, tim_int}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0);
    check("post_rst_cnt_hi", reg_rdata, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 32'h0);
    check("post_rst_cmp_hi", reg_rdata, 32'hFFFFFFFF);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 32'h0);
    check("post_rst_sts", reg_rdata, 32'h0);
    check("post_rst_int", {31'b0, tim_int}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
